// File: rtl/gf_mul68_inv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf_mul68_inv_seq: iterative GF(2^8) multiply by KCONST (0xF4 = 0x68^-1)     |
// | Rev 1.0 -- optional result self-check enabled by GF_MUL68_INV_CHECK_EN      |
// +----------------------------------------------------------------------------+
module gf_mul68_inv_seq #(
  parameter int         UNROLL = 1,
  parameter logic [7:0] KCONST = 8'hF4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef GF_MUL68_INV_CHECK_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] c_UNROLL = 4'(UNROLL);

  state_t     state_q, state_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] acc_step;
  logic [2:0] bit_idx;
  logic [3:0] cnt_sum;
  logic       last_grp;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Step index i = 7 - (cnt + j); for 3-bit values 7 - x is simply ~x.
  always_comb begin
    acc_step = acc_q;
    bit_idx  = '0;
    for (int j = 0; j < UNROLL; j++) begin
      bit_idx  = ~(cnt_q + 3'(j));
      acc_step = xtime(acc_step) ^ (KCONST[bit_idx] ? b_q : 8'h00);
    end
  end

  // The counter lands exactly on 8 when the final step group completes.
  assign cnt_sum  = {1'b0, cnt_q} + c_UNROLL;
  assign last_grp = cnt_sum[3];

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_d     = in_data;
          acc_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_sum[2:0];
        if (last_grp) begin
          out_data_d  = acc_step;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          in_ready    = 1'b1;
          out_valid_d = 1'b0;
          if (in_valid) begin
            b_d     = in_data;
            acc_d   = 8'h00;
            cnt_d   = 3'd0;
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      b_q         <= 8'h00;
      acc_q       <= 8'h00;
      cnt_q       <= 3'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef GF_MUL68_INV_CHECK_EN
  logic       err_q, err_d;
  logic [7:0] chk_prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = xtime(p) ^ (b[i] ? a : 8'h00);
    end
    return p;
  endfunction

  // b_q is still the operand of the held result throughout HOLD.
  always_comb begin
    chk_prod = gf_mul(out_data_q, 8'h68);
    err_d    = err_q | ((state_q == S_HOLD) && (chk_prod != b_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf_mul68_inv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for gf_mul68_inv_seq: four instances (UNROLL 1/2/4/8) driven
// with directed and random bytes, checked against a carry-less multiply model.
module tb_gf_mul68_inv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
    int         acc;
  } item_t;

  // Reference: plain polynomial product, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  task automatic check(input int un, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL u%0d %s: got 0x%0h expected 0x%0h", un, name, act, exp);
    end
  endtask

  for (genvar u = 0; u < 4; u++) begin : g_dut
    localparam int UN  = 1 << u;
    localparam int LAT = 8 / UN;

    logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_data, out_data;
`ifdef GF_MUL68_INV_CHECK_EN
    logic       err;
`endif
    item_t      q[$];
    bit         done = 1'b0;

    gf_mul68_inv_seq #(.UNROLL(UN), .KCONST(8'hF4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
`ifdef GF_MUL68_INV_CHECK_EN
      ,
      .err      (err)
`endif
    );

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [7:0] b, input bit rnd, output int acc_cyc);
      item_t it;
      int    n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = b;
      #1;
      while (!in_ready) begin
        n++;
        if (n > 400) begin
          check(UN, "accept_timeout", 0, 1);
          in_valid = 1'b0;
          acc_cyc  = -1;
          return;
        end
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        #1;
      end
      acc_cyc = cyc + 1;
      it.din  = b;
      it.exp  = gmul(b, 8'hF4);
      it.acc  = cyc + 1;
      q.push_back(it);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    endtask

    task automatic drain();
      int n;
      n         = 0;
      out_ready = 1'b1;
      while (q.size() > 0 && n < 200) begin
        tick();
        n++;
      end
      check(UN, "drain_empty", q.size(), 0);
    endtask

    // Stimulus
    initial begin
      logic [7:0] vec [6];
      int         a, c0, first_a, n;
      vec[0] = 8'h01; vec[1] = 8'h68; vec[2] = 8'hD0;
      vec[3] = 8'hBB; vec[4] = 8'h02; vec[5] = 8'h00;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check(UN, "reset_out_valid", int'(out_valid), 0);
      check(UN, "reset_out_data", int'(out_data), 0);
      check(UN, "reset_busy", int'(busy), 0);
      check(UN, "reset_in_ready", int'(in_ready), 1);
`ifdef GF_MUL68_INV_CHECK_EN
      check(UN, "reset_err", int'(err), 0);
`endif
      foreach (vec[i]) send(vec[i], 1'b0, a);
      drain();

      // Backpressure, then retire-and-accept on the same edge.
      out_ready = 1'b0;
      send(8'h01, 1'b0, a);
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      check(UN, "bp_out_valid_seen", int'(out_valid), 1);
      repeat (20) tick();
      c0 = cyc;
      out_ready = 1'b1;
      send(8'h68, 1'b0, a);
      check(UN, "b2b_same_edge", a, c0 + 1);
      drain();

      // Full byte sweep with the consumer always ready.
      first_a = 0;
      for (int i = 0; i < 256; i++) begin
        send(8'(i), 1'b0, a);
        if (i == 0) first_a = a;
      end
      check(UN, "throughput", a - first_a, 255 * (LAT + 1));
      drain();

      repeat (40) begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        send(8'($urandom), 1'b1, a);
      end
      drain();

      // Reset in the third compute cycle abandons the byte in flight.
      send(8'h55, 1'b0, a);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check(UN, "midrst_out_valid", int'(out_valid), 0);
      check(UN, "midrst_busy", int'(busy), 0);
      check(UN, "midrst_in_ready", int'(in_ready), 1);
      check(UN, "midrst_out_data", int'(out_data), 0);
      send(8'hBB, 1'b0, a);
      drain();
`ifdef GF_MUL68_INV_CHECK_EN
      check(UN, "err_stays_clear", int'(err), 0);
`endif
      done = 1'b1;
    end

    // Monitor
    initial begin
      bit         lat_done;
      logic [7:0] held;
      lat_done = 1'b0;
      held     = 8'h00;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          lat_done = 1'b0;
        end else begin
          check(UN, "busy", int'(busy), int'(q.size() > 0 && q[0].acc <= cyc));
          if (out_valid) begin
            if (q.size() == 0) begin
              check(UN, "spurious_out_valid", 1, 0);
            end else begin
              if (!lat_done) begin
                check(UN, "latency", cyc - q[0].acc, LAT);
                lat_done = 1'b1;
                held     = out_data;
              end else begin
                check(UN, "hold_stable", int'(out_data), int'(held));
              end
              if (!out_ready) begin
                check(UN, "in_ready_backpressure", int'(in_ready), 0);
              end else begin
                check(UN, "out_data", int'(out_data), int'(q[0].exp));
                check(UN, "inverse_roundtrip", int'(gmul(out_data, 8'h68)), int'(q[0].din));
                void'(q.pop_front());
                lat_done = 1'b0;
              end
            end
          end
        end
      end
    end
  end

`ifdef GF_MUL68_INV_CHECK_EN
  logic       k_rst, k_iv, k_ir, k_ov, k_or, k_busy, k_err;
  logic [7:0] k_id, k_od;
  bit         k_done = 1'b0;

  gf_mul68_inv_seq #(.UNROLL(1), .KCONST(8'hF5)) u_kf5 (
    .clk      (clk),
    .rst      (k_rst),
    .in_valid (k_iv),
    .in_ready (k_ir),
    .in_data  (k_id),
    .out_valid(k_ov),
    .out_ready(k_or),
    .out_data (k_od),
    .busy     (k_busy),
    .err      (k_err)
  );

  initial begin
    int n;
    k_rst = 1'b1; k_iv = 1'b0; k_id = 8'h00; k_or = 1'b0;
    repeat (3) @(posedge clk);
    #1 k_rst = 1'b0;
    k_iv = 1'b1; k_id = 8'h01;
    @(posedge clk); #1;
    k_iv = 1'b0;
    n = 0;
    while (!k_ov && n < 50) begin @(posedge clk); #1; n++; end
    check(99, "kf5_out_data", int'(k_od), int'(gmul(8'h01, 8'hF5)));
    check(99, "kf5_err_pre", int'(k_err), 0);
    @(posedge clk); #1;
    check(99, "kf5_err_set", int'(k_err), 1);
    k_or = 1'b1;
    @(posedge clk); #1;
    k_or = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(99, "kf5_err_sticky", int'(k_err), 1);
    check(99, "kf5_busy_idle", int'(k_busy), 0);
    k_rst = 1'b1;
    @(posedge clk); #1;
    k_rst = 1'b0;
    check(99, "kf5_err_cleared", int'(k_err), 0);
    k_done = 1'b1;
  end
`endif

  initial begin
    bit alld;
    int n;
    n    = 0;
    alld = 1'b0;
    while (!alld && n < 80000) begin
      @(posedge clk);
      n++;
      alld = g_dut[0].done && g_dut[1].done && g_dut[2].done && g_dut[3].done;
`ifdef GF_MUL68_INV_CHECK_EN
      alld = alld && k_done;
`endif
    end
    check(0, "global_timeout", int'(alld), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
